// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider: each channel emits a 50%-duty clock
// and a one-cycle tick, with glitch-free run-time reload of its half-period.
module clk_divider_prog #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 26,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 i_clk_FPGA,
  input  logic                 i_reset_n,
  input  logic [CHANNELS-1:0]  i_enable,
  input  logic                 i_sync,
  input  logic                 i_load,
  input  logic [CH_W-1:0]      i_load_ch,
  input  logic [DIV_WIDTH-1:0] i_load_div,
  output logic [CHANNELS-1:0]  o_pending,
  output logic [CHANNELS-1:0]  o_clk,
  output logic [CHANNELS-1:0]  o_tick
);

  localparam logic [DIV_WIDTH-1:0] DEF_L = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);

  logic load_ok;
  assign load_ok = i_load && ({1'b0, i_load_ch} < (CH_W+1)'(CHANNELS));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] lim_q, lim_d;
      logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
      logic                 pend_q, pend_d;
      logic                 clk_q, clk_d;
      logic                 tick_q, tick_d;
      logic                 hit, run, tc, apply;

      always_comb begin
        hit      = load_ok && (i_load_ch == CH_W'(gi));
        run      = i_enable[gi] && (lim_q != '0);
        tc       = run && (cnt_q == lim_q - ONE);
        // A pending value only lands on a half-period boundary or while idle.
        apply    = pend_q && (tc || !i_enable[gi] || (lim_q == '0));
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        if (i_sync) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (pend_q) lim_d = shadow_q;
          pend_d = 1'b0;
        end else begin
          tick_d = tc;
          if (tc) begin
            cnt_d = '0;
            clk_d = ~clk_q;
          end else if (run) begin
            cnt_d = cnt_q + ONE;
          end
          if (apply) begin
            lim_d  = shadow_q;
            cnt_d  = '0;
            pend_d = 1'b0;
          end
        end
        // Capture after apply so a same-cycle load stays pending for the next boundary.
        if (hit) begin
          shadow_d = i_load_div;
          pend_d   = 1'b1;
        end
      end

      always_ff @(posedge i_clk_FPGA) begin
        if (!i_reset_n) begin
          cnt_q    <= '0;
          lim_q    <= DEF_L;
          shadow_q <= DEF_L;
          pend_q   <= 1'b0;
          clk_q    <= 1'b0;
          tick_q   <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          lim_q    <= lim_d;
          shadow_q <= shadow_d;
          pend_q   <= pend_d;
          clk_q    <= clk_d;
          tick_q   <= tick_d;
        end
      end

      assign o_pending[gi] = pend_q;
      assign o_clk[gi]     = clk_q;
      assign o_tick[gi]    = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed scenarios plus random
// traffic against a per-channel behavioural model.
module tb_clk_divider_prog;
  localparam int CH  = 2;
  localparam int DW  = 8;
  localparam int DEF = 5;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          ld = 1'b0;
  logic [CHW-1:0] ld_ch = '0;
  logic [DW-1:0] ld_div = '0;
  logic [CH-1:0] o_pending, o_clk, o_tick;

  int checks = 0;
  int failures = 0;

  int m_cnt[CH], m_lim[CH], m_sh[CH];
  bit m_pend[CH], m_clk[CH], m_tick[CH];

  clk_divider_prog #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .CH_W(CHW)
  ) dut (
    .i_clk_FPGA(clk), .i_reset_n(rst_n), .i_enable(en), .i_sync(sync),
    .i_load(ld), .i_load_ch(ld_ch), .i_load_div(ld_div),
    .o_pending(o_pending), .o_clk(o_clk), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // Reference: applies the channel rules to the inputs seen at this edge.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit hit, run, tc, app;
      hit = ld && (int'(ld_ch) == c);
      if (!rst_n) begin
        m_cnt[c] = 0; m_lim[c] = DEF; m_sh[c] = DEF;
        m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else if (sync) begin
        m_cnt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        if (m_pend[c]) m_lim[c] = m_sh[c];
        m_pend[c] = 0;
        if (hit) begin m_sh[c] = int'(ld_div); m_pend[c] = 1; end
      end else begin
        run = en[c] && (m_lim[c] != 0);
        tc  = run && (m_cnt[c] == m_lim[c] - 1);
        app = m_pend[c] && (tc || !en[c] || m_lim[c] == 0);
        m_tick[c] = tc;
        if (tc) begin m_clk[c] = !m_clk[c]; m_cnt[c] = 0; end
        else if (run) m_cnt[c] = m_cnt[c] + 1;
        if (app) begin m_lim[c] = m_sh[c]; m_cnt[c] = 0; m_pend[c] = 0; end
        if (hit) begin m_sh[c] = int'(ld_div); m_pend[c] = 1; end
      end
    end
  endtask

  function automatic logic [3*CH-1:0] expv();
    logic [3*CH-1:0] v;
    for (int c = 0; c < CH; c++) begin
      v[c] = m_tick[c]; v[CH+c] = m_clk[c]; v[2*CH+c] = m_pend[c];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic edge_with_load(input int ch, input int div);
    ld = 1'b1; ld_ch = CHW'(ch); ld_div = DW'(div);
    $display("load ch=%0d div=%0d t=%0t", ch, div, $time);
    step();
    ld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = '0; sync = 1'b0; ld = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_pending, o_clk, o_tick} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {o_pending, o_clk, o_tick});
    end
    en = 2'b11;
    edge_with_load(0, 2);
    step(); step();
    checks++;
    if (o_pending !== 2'b01) begin
      failures++; $display("FAIL pending_before_reset got=%b exp=01", o_pending);
    end
    do_reset();
    checks++;
    if (o_pending !== 2'b00) begin
      failures++; $display("FAIL reset_discards_pending got=%b exp=00", o_pending);
    end
    en = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (o_tick !== ((e == 5) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL reset_default_div edge=%0d got=%b", e, o_tick);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    en = 2'b11;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (o_tick !== ((e % 5 == 0) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL basic_tick edge=%0d got=%b", e, o_tick);
      end
      checks++;
      if (o_clk !== (((e / 5) % 2 == 1) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL basic_clk edge=%0d got=%b", e, o_clk);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 2'b11;
    step();
    edge_with_load(0, 3);
    checks++;
    if (o_pending !== 2'b01) begin
      failures++; $display("FAIL load_pending got=%b exp=01", o_pending);
    end
    for (int e = 3; e <= 14; e++) begin
      step();
      checks++;
      if (o_tick[0] !== ((e == 5) || (e > 5 && (e - 5) % 3 == 0))) begin
        failures++; $display("FAIL load_tick0 edge=%0d got=%b", e, o_tick[0]);
      end
      checks++;
      if (o_pending[0] !== (e < 5)) begin
        failures++; $display("FAIL load_pending0 edge=%0d got=%b", e, o_pending[0]);
      end
      checks++;
      if ({o_pending, o_clk, o_tick} !== expv()) begin
        failures++; $display("FAIL load_model edge=%0d got=%b exp=%b", e, {o_pending, o_clk, o_tick}, expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    int falls;
    logic prev;
    do_reset();
    en = 2'b11;
    step();
    edge_with_load(1, 2);
    edge_with_load(1, 7);
    falls = 0;
    prev = o_pending[1];
    for (int e = 4; e <= 20; e++) begin
      step();
      if (prev && !o_pending[1]) falls++;
      prev = o_pending[1];
      checks++;
      if (o_tick[1] !== (e == 5 || e == 12 || e == 19)) begin
        failures++; $display("FAIL overwrite_tick1 edge=%0d got=%b", e, o_tick[1]);
      end
      checks++;
      if (o_pending[1] !== (e < 5)) begin
        failures++; $display("FAIL overwrite_pending1 edge=%0d got=%b", e, o_pending[1]);
      end
    end
    checks++;
    if (falls !== 1) begin
      failures++; $display("FAIL overwrite_apply_count got=%0d exp=1", falls);
    end
  endtask

  task automatic test_l1_l0();
    logic prev_clk;
    do_reset();
    en = 2'b11;
    edge_with_load(0, 1);
    for (int e = 2; e <= 5; e++) step();
    prev_clk = o_clk[0];
    for (int e = 6; e <= 10; e++) begin
      step();
      checks++;
      if (o_tick[0] !== 1'b1 || o_clk[0] === prev_clk) begin
        failures++; $display("FAIL l1_divide edge=%0d tick=%b clk=%b prev=%b", e, o_tick[0], o_clk[0], prev_clk);
      end
      prev_clk = o_clk[0];
    end
    edge_with_load(0, 0);
    step(); step();
    prev_clk = o_clk[0];
    for (int e = 14; e <= 18; e++) begin
      step();
      checks++;
      if (o_tick[0] !== 1'b0 || o_clk[0] !== prev_clk) begin
        failures++; $display("FAIL l0_stall edge=%0d tick=%b clk=%b exp_clk=%b", e, o_tick[0], o_clk[0], prev_clk);
      end
      checks++;
      if ({o_pending, o_clk, o_tick} !== expv()) begin
        failures++; $display("FAIL l0_model edge=%0d got=%b exp=%b", e, {o_pending, o_clk, o_tick}, expv());
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 2'b11;
    for (int e = 1; e <= 7; e++) step();
    en = 2'b01;
    for (int e = 8; e <= 11; e++) begin
      step();
      checks++;
      if (o_tick[1] !== 1'b0 || o_clk[1] !== 1'b1) begin
        failures++; $display("FAIL enable_hold edge=%0d tick=%b clk=%b exp_clk=1", e, o_tick[1], o_clk[1]);
      end
    end
    en = 2'b11;
    for (int e = 12; e <= 20; e++) begin
      step();
      checks++;
      if (o_tick[1] !== (e == 14 || e == 19)) begin
        failures++; $display("FAIL enable_resume_tick edge=%0d got=%b", e, o_tick[1]);
      end
      checks++;
      if (o_clk[1] !== (e >= 14 && e < 19 ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL enable_resume_clk edge=%0d got=%b", e, o_clk[1]);
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    en = 2'b11;
    edge_with_load(1, 3);
    for (int e = 2; e <= 7; e++) step();
    edge_with_load(0, 4);
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (o_clk !== 2'b00 || o_tick !== 2'b00 || o_pending !== 2'b00) begin
      failures++; $display("FAIL sync_state clk=%b tick=%b pend=%b exp=00", o_clk, o_tick, o_pending);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (o_tick !== {1'(k % 3 == 0), 1'(k % 4 == 0)}) begin
        failures++; $display("FAIL sync_phase k=%0d got=%b", k, o_tick);
      end
    end
    edge_with_load(3, 1);
    edge_with_load(2, 1);
    checks++;
    if (o_pending !== 2'b00) begin
      failures++; $display("FAIL load_out_of_range got=%b exp=00", o_pending);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en     = CH'($urandom);
      sync   = ($urandom_range(0, 39) == 0);
      ld     = ($urandom_range(0, 3) == 0);
      ld_ch  = CHW'($urandom_range(0, 3));
      ld_div = DW'($urandom_range(0, 6));
      rst_n  = ($urandom_range(0, 199) != 0);
      step();
      checks++;
      if ({o_pending, o_clk, o_tick} !== expv()) begin
        failures++; $display("FAIL random_model cycle=%0d got=%b exp=%b", i, {o_pending, o_clk, o_tick}, expv());
      end
    end
    rst_n = 1'b1; sync = 1'b0; ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_back_to_back();
    test_l1_l0();
    test_enable();
    test_sync();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
